// File: rtl/stream_writer_src.sv
// Buffered stream source: a local producer fills a circular FIFO, and words are replayed in order
// on a valid/ready master port under control of an LFSR-based rate throttle.
module stream_writer_src #(
  parameter int WIDTH          = 32,
  parameter int MAX_BLOCK_SIZE = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  load_data_i,
  input  logic                              load_valid_i,
  output logic                              load_ready_o,
  input  logic [7:0]                        rate_i,
  output logic [WIDTH-1:0]                  stream_m_data_o,
  output logic                              stream_m_valid_o,
  input  logic                              stream_m_ready_i,
  output logic [$clog2(MAX_BLOCK_SIZE):0]   count_o,
  output logic [31:0]                       words_sent_o
);

  localparam int AW = $clog2(MAX_BLOCK_SIZE);
  localparam int CW = AW + 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right with the output taken from bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [WIDTH-1:0] mem_q [MAX_BLOCK_SIZE];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [31:0]      sent_q, sent_d;

  logic eligible, slot_free, push, pop, handshake;

  assign load_ready_o     = (count_q < CW'(MAX_BLOCK_SIZE));
  assign eligible         = (rate_i == 8'hFF) || (lfsr_q[7:0] < rate_i);
  assign slot_free        = !valid_q || stream_m_ready_i;
  assign push             = load_valid_i && load_ready_o && !rst;
  assign pop              = slot_free && (count_q != '0) && eligible;
  assign handshake        = valid_q && stream_m_ready_i;

  assign stream_m_data_o  = data_q;
  assign stream_m_valid_o = valid_q;
  assign count_o          = count_q;
  assign words_sent_o     = sent_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = valid_q;
    lfsr_d   = lfsr_step(lfsr_q);
    sent_d   = handshake ? sent_q + 32'd1 : sent_q;
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A presented word is only replaced once the sink has taken it; the throttle can't retract it.
    if (slot_free) begin
      if (pop) begin
        data_d  = mem_q[rd_ptr_q];
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      sent_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      lfsr_q   <= lfsr_d;
      sent_q   <= sent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= load_data_i;
  end

endmodule

// File: tb/tb_stream_writer_src.sv
// Directed bench for stream_writer_src: table of single-cycle vectors plus multi-cycle sequences.
module tb_stream_writer_src;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] load_data_i = '0;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic [7:0]  rate_i = 8'hFF;
  logic [31:0] stream_m_data_o;
  logic        stream_m_valid_o;
  logic        stream_m_ready_i = 1'b1;
  logic [5:0]  count_o;
  logic [31:0] words_sent_o;

  int checks = 0;
  int errors = 0;

  stream_writer_src #(.WIDTH(32), .MAX_BLOCK_SIZE(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .load_data_i      (load_data_i),
    .load_valid_i     (load_valid_i),
    .load_ready_o     (load_ready_o),
    .rate_i           (rate_i),
    .stream_m_data_o  (stream_m_data_o),
    .stream_m_valid_o (stream_m_valid_o),
    .stream_m_ready_i (stream_m_ready_i),
    .count_o          (count_o),
    .words_sent_o     (words_sent_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [5:0]  ec;
    logic [31:0] es;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, rx, loaded, rxn, lowcyc, bad, sawv;
    logic will;
    logic [5:0]  maxc;
    logic [31:0] base, e, w;
    logic [31:0] exp_q [$];

    // Full-rate A0..A3 burst, then a word parked under backpressure.
    vecs[0] = '{1'b1, 32'hA0, 1'b1, 1'b0, 32'h0,  6'd1, 32'd0};
    vecs[1] = '{1'b1, 32'hA1, 1'b1, 1'b1, 32'hA0, 6'd1, 32'd0};
    vecs[2] = '{1'b1, 32'hA2, 1'b1, 1'b1, 32'hA1, 6'd1, 32'd1};
    vecs[3] = '{1'b1, 32'hA3, 1'b1, 1'b1, 32'hA2, 6'd1, 32'd2};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA3, 6'd0, 32'd3};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hA3, 6'd0, 32'd4};
    vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hA3, 6'd0, 32'd4};
    vecs[7] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 32'hA3, 6'd1, 32'd4};
    vecs[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h12345678, 6'd0, 32'd4};

    // Reset
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset valid", stream_m_valid_o, 0);
    check("reset data", stream_m_data_o, 0);
    check("reset count", count_o, 0);
    check("reset load_ready", load_ready_o, 1);
    check("reset words_sent", words_sent_o, 0);

    // Table vectors
    rate_i = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      load_valid_i     = vecs[i].lv;
      load_data_i      = vecs[i].ld;
      stream_m_ready_i = vecs[i].rdy;
      step();
      check($sformatf("vec%0d valid", i), stream_m_valid_o, vecs[i].ev);
      check($sformatf("vec%0d data", i), stream_m_data_o, vecs[i].ed);
      check($sformatf("vec%0d count", i), count_o, vecs[i].ec);
      check($sformatf("vec%0d words_sent", i), words_sent_o, vecs[i].es);
    end

    // Backpressure hold
    stream_m_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp%0d valid", i), stream_m_valid_o, 1);
      check($sformatf("bp%0d data", i), stream_m_data_o, 32'h12345678);
    end
    stream_m_ready_i = 1'b1;
    step();
    check("bp release words_sent", words_sent_o, 5);
    check("bp release valid", stream_m_valid_o, 0);

    // Full buffer
    stream_m_ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      load_valid_i = 1'b1;
      load_data_i  = 32'h100 + acc;
      will = load_ready_o;
      step();
      if (will) acc++;
    end
    load_valid_i = 1'b0;
    check("full accepted", acc, 33);
    check("full count", count_o, 32);
    check("full load_ready", load_ready_o, 0);
    stream_m_ready_i = 1'b1;
    rx = 0;
    for (int c = 0; c < 100 && rx < 33; c++) begin
      if (stream_m_valid_o) begin
        check($sformatf("full drain word%0d", rx), stream_m_data_o, 32'h100 + rx);
        rx++;
      end
      step();
      if (c == 0) begin
        check("full first pop load_ready", load_ready_o, 1);
        check("full first pop count", count_o, 31);
      end
    end
    check("full drained words", rx, 33);
    check("full words_sent", words_sent_o, 38);

    // Throttled run
    rate_i = 8'd25;
    stream_m_ready_i = 1'b1;
    base = words_sent_o;
    loaded = 0; rxn = 0; lowcyc = 0; bad = 0; maxc = '0;
    for (int c = 0; c < 40000 && rxn < 1000; c++) begin
      if (stream_m_valid_o) begin
        if (exp_q.size() == 0) bad++;
        else begin
          e = exp_q.pop_front();
          if (stream_m_data_o !== e) bad++;
        end
        rxn++;
      end else lowcyc++;
      if (count_o > maxc) maxc = count_o;
      load_valid_i = (loaded < 1000);
      w = $urandom;
      load_data_i = w;
      if (load_valid_i && load_ready_o) begin
        exp_q.push_back(w);
        loaded++;
      end
      step();
    end
    load_valid_i = 1'b0;
    check("throttle received", rxn, 1000);
    check("throttle order errors", bad, 0);
    check("throttle words_sent delta", words_sent_o - base, 1000);
    check("throttle valid low seen", (lowcyc > 0), 1);
    check("throttle max count ok", (maxc <= 6'd32), 1);

    // Rate 0 then mid-stream reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    rate_i = 8'd0;
    for (int i = 0; i < 5; i++) begin
      load_valid_i = 1'b1;
      load_data_i  = 32'h500 + i;
      step();
    end
    load_valid_i = 1'b0;
    check("rate0 count", count_o, 5);
    sawv = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (stream_m_valid_o) sawv++;
    end
    check("rate0 valid cycles", sawv, 0);
    rate_i = 8'hFF;
    for (int c = 0; c < 20 && words_sent_o < 2; c++) step();
    check("pre-reset words_sent", words_sent_o, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst count", count_o, 0);
    check("midrst valid", stream_m_valid_o, 0);
    check("midrst words_sent", words_sent_o, 0);
    check("midrst data", stream_m_data_o, 0);
    sawv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (stream_m_valid_o) sawv++;
    end
    check("midrst stale valid cycles", sawv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
